mux4_rr_feeder: RTL and testbench
=================================

# mux4_rr_feeder

Round-robin select sequencer that sits directly upstream of the 4:1 multibit gate-level mux. It arbitrates among four requesting sources (a, b, c, d), drives the mux's 2-bit select `sl`, and registers the mux output `o` one cycle later into a valid/ready output stage. This gives the combinational mux a registered, handshaked front end for fault-simulation benches and for system use.

## Interface
- `W`, default 4: data width; must match the mux data width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 4: request per source; bit0=a, bit1=b, bit2=c, bit3=d.
- `in_ready` output 4: one-hot accept pulse to the granted source.
- `sl` output 2: registered select to the mux; 0=a, 1=b, 2=c, 3=d.
- `mux_o` input W: mux output `o`, fed back for capture.
- `out_valid` output 1: captured word available.
- `out_ready` input 1: downstream accepts the word.
- `out_data` output W: captured mux output.
- `out_ch` output 2: source index of `out_data`.
- `out_par` output 1: present only with `MUX4_FEED_PARITY_EN`.

## Operation
- States: IDLE, SETTLE, HOLD. `last` holds the 2-bit pointer to the last granted source.
- Round-robin pick: first set bit of `in_valid`, searching `last+1`, `last+2`, `last+3`, `last` (mod 4).
- IDLE: if any `in_valid` is set, `sl` <= pick and the FSM goes to SETTLE. Otherwise it stays in IDLE, and `sl` holds its value.
- SETTLE: the mux settles during this cycle. `in_ready[sl]` = `in_valid[sl]` (combinational, one-hot, asserted only in SETTLE).
  - If `in_valid[sl]`=1: at the clock edge, `out_data` <= `mux_o`, `out_ch` <= `sl`, `last` <= `sl`, `out_valid` <= 1, and the FSM goes to HOLD.
  - If `in_valid[sl]`=0 (source withdrew): no capture, no `in_ready`, `last` is unchanged, and the FSM returns to IDLE.
- HOLD: `out_valid`=1; `out_data`, `out_ch` and `sl` are stable.
  - `out_ready`=0: stay in HOLD.
  - `out_ready`=1 and any `in_valid` set: `out_valid` <= 0, `sl` <= pick, go to SETTLE.
  - `out_ready`=1 and no `in_valid` set: `out_valid` <= 0, go to IDLE.
- Sources must hold `in_valid` and their data until they see `in_ready`. The block does not buffer source data; the mux reads the sources live.
- Reset values: state=IDLE, `sl`=0, `last`=3 (so source a has first priority), `out_valid`=0, `out_data`=0, `out_ch`=0, `out_par`=0, `in_ready`=0.

## Timing
- Latency: `in_valid` seen in IDLE at cycle N gives `sl` valid at N+1, `in_ready` pulsed at N+1, and `out_valid`=1 at N+2.
- Throughput: with `out_ready` held at 1, one word every 2 cycles (alternating SETTLE and HOLD).
- Only one `in_ready` bit is high in any cycle, for exactly one cycle per accepted word.
- `sl` changes only on IDLE->SETTLE or HOLD->SETTLE transitions. It is never changed during SETTLE, because the mux path must be stable for the full cycle.
- Simultaneous `out_ready` and new requests in HOLD: the word is retired and the next grant is issued in the same edge, with no idle bubble.
- Reset asserted mid-operation (any state): all registers take their reset values on that edge. A word held in HOLD is discarded, and no `in_ready` is issued in the reset cycle.

## Configuration
- `MUX4_FEED_PARITY_EN` defined:
  - Adds the `out_par` output.
  - `out_par` <= ^`mux_o` at the same edge that captures `out_data`, and it is held through HOLD.
  - Reset value is 0.
- `MUX4_FEED_PARITY_EN` undefined: the `out_par` port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, then `in_valid`=4'b0001, a=4'hA at the mux, `out_ready`=1 → `sl`=0 at cycle 1, `in_ready`=4'b0001 at cycle 1, `out_valid`=1 with `out_data`=4'hA and `out_ch`=0 at cycle 2.
- `in_valid`=4'b1111 held, `out_ready`=1, a/b/c/d = 1/2/3/4 → `out_ch` sequence 0,1,2,3,0, one word every 2 cycles, `out_data` sequence 1,2,3,4,1.
- `out_ready`=0 for 5 cycles while in HOLD with `out_data`=4'h5 → `out_valid`, `out_data` and `sl` stay constant, and `in_ready`=0 throughout. When `out_ready` rises, the next grant is issued on the same edge.
- In SETTLE, drop `in_valid[2]` → no `in_ready`, no `out_valid`, return to IDLE, and `last` is unchanged (the next grant with all requests set goes to 3 if `last` was 2, otherwise follows the unchanged pointer).
- Assert `rst` for one cycle while in HOLD → next cycle `out_valid`=0, `sl`=0, `out_ch`=0, and a subsequent `in_valid`=4'b1111 grants source a first.
- With `MUX4_FEED_PARITY_EN` defined, captured `mux_o`=4'b0111 → `out_par`=1; captured 4'b0110 → `out_par`=0.

Source files
------------

// File: rtl/mux4_rr_feeder.sv
// Round-robin select sequencer for a 4:1 mux with a registered valid/ready output stage.
// Optional parity output enabled by defining MUX4_FEED_PARITY_EN.
module mux4_rr_feeder #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    output logic [1:0]   sl,
    input  logic [W-1:0] mux_o,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_ch
`ifdef MUX4_FEED_PARITY_EN
    ,
    output logic         out_par
`endif
);

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    state_e       state_q, state_d;
    logic [1:0]   sl_q, sl_d;
    logic [1:0]   last_q, last_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [1:0]   out_ch_q, out_ch_d;
    logic [1:0]   pick;
    logic         any_valid;
`ifdef MUX4_FEED_PARITY_EN
    logic         out_par_q, out_par_d;
`endif

    assign any_valid = |in_valid;

    // Round-robin pick: scan last+4 down to last+1 so the nearest requester after last wins.
    always_comb begin
        pick = last_q;
        for (int i = 4; i >= 1; i--) begin
            if (in_valid[last_q + 2'(i)]) begin
                pick = last_q + 2'(i);
            end
        end
    end

    // One-hot accept pulse to the selected source, only while the mux is settling.
    always_comb begin
        in_ready = '0;
        if (state_q == StSettle && !rst && in_valid[sl_q]) begin
            in_ready[sl_q] = 1'b1;
        end
    end

    // Next-state logic; sl only moves when entering SETTLE so the mux path is stable.
    always_comb begin
        state_d     = state_q;
        sl_d        = sl_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
`ifdef MUX4_FEED_PARITY_EN
        out_par_d   = out_par_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    sl_d    = pick;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (in_valid[sl_q]) begin
                    out_data_d  = mux_o;
                    out_ch_d    = sl_q;
                    last_d      = sl_q;
                    out_valid_d = 1'b1;
`ifdef MUX4_FEED_PARITY_EN
                    out_par_d   = ^mux_o;
`endif
                    state_d     = StHold;
                end else begin
                    // Source withdrew before accept: drop the grant, keep the pointer.
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (any_valid) begin
                        sl_d    = pick;
                        state_d = StSettle;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset; last resets to 3 so source a goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sl_q        <= 2'd0;
            last_q      <= 2'd3;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= 2'd0;
`ifdef MUX4_FEED_PARITY_EN
            out_par_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sl_q        <= sl_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
`ifdef MUX4_FEED_PARITY_EN
            out_par_q   <= out_par_d;
`endif
        end
    end

    assign sl        = sl_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
`ifdef MUX4_FEED_PARITY_EN
    assign out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_mux4_rr_feeder.sv
// Table-driven bench for mux4_rr_feeder; each row is one clock cycle of inputs plus the
// outputs expected during that cycle (before the next rising edge).
module tb_mux4_rr_feeder;

    localparam int unsigned W = 4;
    localparam int NV = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [1:0]   sl;
    logic [W-1:0] mux_o;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_ch;
`ifdef MUX4_FEED_PARITY_EN
    logic         out_par;
`endif

    // Source data; the external mux is modelled combinationally from sl.
    logic [W-1:0] src_a, src_b, src_c, src_d;
    assign mux_o = (sl == 2'd0) ? src_a : (sl == 2'd1) ? src_b : (sl == 2'd2) ? src_c : src_d;

    always #5 clk = ~clk;

    mux4_rr_feeder #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sl        (sl),
        .mux_o     (mux_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
`ifdef MUX4_FEED_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    typedef struct {
        logic         rst;
        logic [3:0]   iv;
        logic         ordy;
        logic [W-1:0] a;
        logic [1:0]   e_sl;
        logic [3:0]   e_ir;
        logic         e_ov;
        logic [W-1:0] e_d;
        logic [1:0]   e_ch;
    } vec_t;

    vec_t vec [NV];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(logic r, logic [3:0] iv, logic ordy, logic [W-1:0] a,
                                logic [1:0] s, logic [3:0] ir, logic ov, logic [W-1:0] d,
                                logic [1:0] ch);
        vec_t v;
        v.rst = r; v.iv = iv; v.ordy = ordy; v.a = a;
        v.e_sl = s; v.e_ir = ir; v.e_ov = ov; v.e_d = d; v.e_ch = ch;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_out_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        //              rst iv       ordy a      sl     ir       ov    d      ch
        // single request from a
        vec[0]  = mk(0, 4'b0001, 1, 4'hA, 2'd0, 4'b0000, 0, 4'h0, 2'd0);
        vec[1]  = mk(0, 4'b0001, 1, 4'hA, 2'd0, 4'b0001, 0, 4'h0, 2'd0);
        vec[2]  = mk(0, 4'b0000, 1, 4'hA, 2'd0, 4'b0000, 1, 4'hA, 2'd0);
        vec[3]  = mk(0, 4'b0000, 1, 4'hA, 2'd0, 4'b0000, 0, 4'hA, 2'd0);
        vec[4]  = mk(1, 4'b0000, 1, 4'hA, 2'd0, 4'b0000, 0, 4'hA, 2'd0);
        // all requesting, full throughput: ch 0,1,2,3,0
        vec[5]  = mk(0, 4'b1111, 1, 4'h1, 2'd0, 4'b0000, 0, 4'h0, 2'd0);
        vec[6]  = mk(0, 4'b1111, 1, 4'h1, 2'd0, 4'b0001, 0, 4'h0, 2'd0);
        vec[7]  = mk(0, 4'b1111, 1, 4'h1, 2'd0, 4'b0000, 1, 4'h1, 2'd0);
        vec[8]  = mk(0, 4'b1111, 1, 4'h1, 2'd1, 4'b0010, 0, 4'h1, 2'd0);
        vec[9]  = mk(0, 4'b1111, 1, 4'h1, 2'd1, 4'b0000, 1, 4'h2, 2'd1);
        vec[10] = mk(0, 4'b1111, 1, 4'h1, 2'd2, 4'b0100, 0, 4'h2, 2'd1);
        vec[11] = mk(0, 4'b1111, 1, 4'h1, 2'd2, 4'b0000, 1, 4'h3, 2'd2);
        vec[12] = mk(0, 4'b1111, 1, 4'h1, 2'd3, 4'b1000, 0, 4'h3, 2'd2);
        vec[13] = mk(0, 4'b1111, 1, 4'h1, 2'd3, 4'b0000, 1, 4'h4, 2'd3);
        vec[14] = mk(0, 4'b1111, 1, 4'h1, 2'd0, 4'b0001, 0, 4'h4, 2'd3);
        vec[15] = mk(0, 4'b1111, 1, 4'h1, 2'd0, 4'b0000, 1, 4'h1, 2'd0);
        vec[16] = mk(0, 4'b1111, 1, 4'h1, 2'd1, 4'b0010, 0, 4'h1, 2'd0);
        // reset while holding a word from b
        vec[17] = mk(1, 4'b1111, 1, 4'h1, 2'd1, 4'b0000, 1, 4'h2, 2'd1);
        vec[18] = mk(0, 4'b1111, 1, 4'h1, 2'd0, 4'b0000, 0, 4'h0, 2'd0);
        vec[19] = mk(0, 4'b1111, 0, 4'h5, 2'd0, 4'b0001, 0, 4'h0, 2'd0);
        // backpressure for 5 cycles, then grant on the same edge as retire
        vec[20] = mk(0, 4'b1111, 0, 4'h5, 2'd0, 4'b0000, 1, 4'h5, 2'd0);
        vec[21] = mk(0, 4'b1111, 0, 4'h5, 2'd0, 4'b0000, 1, 4'h5, 2'd0);
        vec[22] = mk(0, 4'b1111, 0, 4'h5, 2'd0, 4'b0000, 1, 4'h5, 2'd0);
        vec[23] = mk(0, 4'b1111, 0, 4'h5, 2'd0, 4'b0000, 1, 4'h5, 2'd0);
        vec[24] = mk(0, 4'b1111, 0, 4'h5, 2'd0, 4'b0000, 1, 4'h5, 2'd0);
        vec[25] = mk(0, 4'b1111, 1, 4'h5, 2'd0, 4'b0000, 1, 4'h5, 2'd0);
        vec[26] = mk(0, 4'b1111, 1, 4'h5, 2'd1, 4'b0010, 0, 4'h5, 2'd0);
        vec[27] = mk(0, 4'b1111, 1, 4'h5, 2'd1, 4'b0000, 1, 4'h2, 2'd1);
        // c withdraws during SETTLE; pointer stays at 1 so c is picked again
        vec[28] = mk(0, 4'b1011, 1, 4'h5, 2'd2, 4'b0000, 0, 4'h2, 2'd1);
        vec[29] = mk(0, 4'b1111, 1, 4'h5, 2'd2, 4'b0000, 0, 4'h2, 2'd1);
        vec[30] = mk(0, 4'b1111, 1, 4'h5, 2'd2, 4'b0100, 0, 4'h2, 2'd1);
        vec[31] = mk(0, 4'b0000, 1, 4'h5, 2'd2, 4'b0000, 1, 4'h3, 2'd2);

        src_a = 4'h0; src_b = 4'h2; src_c = 4'h3; src_d = 4'h4;
        in_valid = 4'b0000;
        out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vec[i].rst;
            in_valid = vec[i].iv;
            out_ready = vec[i].ordy;
            src_a = vec[i].a;
            #1;
            chk($sformatf("row%0d sl", i), 32'(sl), 32'(vec[i].e_sl));
            chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(vec[i].e_ir));
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vec[i].e_ov));
            chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(vec[i].e_d));
            chk($sformatf("row%0d out_ch", i), 32'(out_ch), 32'(vec[i].e_ch));
        end

        // Capture of 4'b0111 then 4'b0110 from source a, with a bounded wait for each word.
        @(negedge clk);
        rst = 1'b1;
        in_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        src_a = 4'b0111;
        in_valid = 4'b0001;
        out_ready = 1'b0;
        wait_out_valid(ok);
        chk("word7 out_valid seen", 32'(ok), 32'd1);
        chk("word7 out_data", 32'(out_data), 32'h7);
`ifdef MUX4_FEED_PARITY_EN
        chk("word7 out_par", 32'(out_par), 32'd1);
`endif
        in_valid = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        src_a = 4'b0110;
        in_valid = 4'b0001;
        out_ready = 1'b0;
        wait_out_valid(ok);
        chk("word6 out_valid seen", 32'(ok), 32'd1);
        chk("word6 out_data", 32'(out_data), 32'h6);
`ifdef MUX4_FEED_PARITY_EN
        chk("word6 out_par", 32'(out_par), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
